// File: rtl/tree_ensemble_vote_ctrl.sv
// Vote controller for a bank of per-class decision trees. It sweeps every (class, tree)
// pair for one latched feature vector, counts the votes per class and reports the argmax class.
module tree_ensemble_vote_ctrl #(
    parameter int FEAT_W          = 51,
    parameter int NUM_CLASSES     = 4,
    parameter int TREES_PER_CLASS = 3,
    parameter int CLASS_W         = 2,
    parameter int TREE_W          = 2,
    parameter int VOTE_W          = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FEAT_W-1:0]  in_feat,
    output logic [FEAT_W-1:0]  tree_feat,
    output logic [CLASS_W-1:0] tree_class_sel,
    output logic [TREE_W-1:0]  tree_idx_sel,
    input  logic               tree_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic [VOTE_W-1:0]  out_votes,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, EVAL, RESOLVE, DONE} state_t;

    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [TREE_W-1:0]  LAST_TREE  = TREE_W'(TREES_PER_CLASS - 1);

    state_t             state;
    logic [VOTE_W-1:0]  votes [NUM_CLASSES];
    logic [CLASS_W-1:0] best_class;
    logic [VOTE_W-1:0]  best_votes;

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    // NOTE: blocking assignments here form an ordered priority chain; strict '>' keeps the lowest index on ties.
    always_comb begin
        best_class = '0;
        best_votes = votes[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (votes[c] > best_votes) begin
                best_class = CLASS_W'(c);
                best_votes = votes[c];
            end
        end
    end

    // NOTE: the vote counters are ordinary flops, so they take the synchronous reset with the control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            tree_feat      <= '0;
            tree_class_sel <= '0;
            tree_idx_sel   <= '0;
            out_valid      <= 1'b0;
            out_class      <= '0;
            out_votes      <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                votes[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tree_feat      <= in_feat;
                        tree_class_sel <= '0;
                        tree_idx_sel   <= '0;
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            votes[c] <= '0;
                        end
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (tree_result) begin
                        votes[tree_class_sel] <= votes[tree_class_sel] + VOTE_W'(1);
                    end
                    // Tree index runs fastest; selects return to zero after the final pair.
                    if (tree_idx_sel == LAST_TREE) begin
                        tree_idx_sel <= '0;
                        if (tree_class_sel == LAST_CLASS) begin
                            tree_class_sel <= '0;
                            state          <= RESOLVE;
                        end else begin
                            tree_class_sel <= tree_class_sel + 1'b1;
                        end
                    end else begin
                        tree_idx_sel <= tree_idx_sel + 1'b1;
                    end
                end
                RESOLVE: begin
                    out_class <= best_class;
                    out_votes <= best_votes;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A class can never collect more votes than it has trees.
    vote_overflow: assert property (@(posedge clk) disable iff (rst)
        (state == EVAL && tree_result) |-> (votes[tree_class_sel] < VOTE_W'(TREES_PER_CLASS)));

endmodule
